// File: rtl/collision_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : collision_pkg
//  Description : Shared definitions for the collision detector: bit positions
//                inside the collision vector, vector widths and the player
//                damage state encoding.
//                Build option COLLISION_BODY_CONTACT_EN adds a body-contact
//                bit (index 5) to the per-frame summary.
//  Revision    : 1.0 - initial release
// ============================================================================
package collision_pkg;

    // Bit positions inside the per-pixel collision vector
    localparam int COL_PMISSILE_MONSTER = 0;
    localparam int COL_MONSTER_BORDER   = 1;
    localparam int COL_MMISSILE_PLAYER  = 2;
    localparam int COL_PMISSILE_BORDER  = 3;
    localparam int COL_MMISSILE_BORDER  = 4;

    localparam int COL_WIDTH = 5;

`ifdef COLLISION_BODY_CONTACT_EN
    // Body contact only appears in the frame summary, never in collision
    localparam int COL_BODY_CONTACT = 5;
    localparam int FRAME_WIDTH      = COL_WIDTH + 1;
`else
    localparam int FRAME_WIDTH      = COL_WIDTH;
`endif

    typedef logic [COL_WIDTH-1:0]   collision_t;
    typedef logic [FRAME_WIDTH-1:0] frame_collision_t;

    typedef enum logic [1:0] {
        VULNERABLE = 2'd0,
        INVULN     = 2'd1,
        DEAD       = 2'd2
    } player_state_t;

endpackage
`default_nettype wire

// File: rtl/hit_cooldown.sv
`default_nettype none
// ============================================================================
//  Module      : hit_cooldown
//  Description : Invulnerability frame counter. A load sets the counter to
//                INVULN_FRAMES; every startOfFrame afterwards counts it down.
//                done flags the startOfFrame that takes the counter from 1
//                to 0, i.e. the last frame boundary still covered.
//  Ports       : clk, reset (async, active-high), load, startOfFrame -> done
//  Revision    : 1.0 - initial release
// ============================================================================
module hit_cooldown #(
    parameter int INVULN_FRAMES = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic startOfFrame,
    output logic done
);

    // $clog2(1) is 0, so a zero-frame window still needs one counter bit
    localparam int                c_cnt_w    = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(INVULN_FRAMES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_cnt_load;
        end else if (startOfFrame && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_cnt_one;
        end
    end

    assign done = startOfFrame && (r_cnt == c_cnt_one);

endmodule
`default_nettype wire

// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : collision_detector
//  Description : Builds the 5-bit per-pixel collision vector from the layer
//                draw requests, ORs it over each video frame into a frame
//                summary, and runs the player damage FSM (lives,
//                invulnerability window, game over).
//                Build option COLLISION_BODY_CONTACT_EN: player/monster body
//                contact also counts as a hit and is reported in
//                frame_collision[5].
//  Ports       : clk, reset (async, active-high), startOfFrame,
//                playerDR, playerMissileDR, monsterDR, monsterMissileDR,
//                borderDR -> collision[4:0], frame_collision,
//                player_hit_pulse, invulnerable, lives[3:0], game_over
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_detector
    import collision_pkg::*;
#(
    parameter int INVULN_FRAMES = 60,
    parameter int INITIAL_LIVES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   playerDR,
    input  logic                   playerMissileDR,
    input  logic                   monsterDR,
    input  logic                   monsterMissileDR,
    input  logic                   borderDR,
    output logic [COL_WIDTH-1:0]   collision,
    output logic [FRAME_WIDTH-1:0] frame_collision,
    output logic                   player_hit_pulse,
    output logic                   invulnerable,
    output logic [3:0]             lives,
    output logic                   game_over
);

    localparam logic [3:0] c_init_lives = 4'(INITIAL_LIVES);
    localparam logic [3:0] c_one_life   = 4'd1;

    // ------------------------------------------------------------------
    // Per-pixel collision vector
    // ------------------------------------------------------------------
    collision_t w_coll_raw;

    always_comb begin
        w_coll_raw                       = '0;
        w_coll_raw[COL_PMISSILE_MONSTER] = playerMissileDR  & monsterDR;
        w_coll_raw[COL_MONSTER_BORDER]   = monsterDR        & borderDR;
        w_coll_raw[COL_MMISSILE_PLAYER]  = monsterMissileDR & playerDR;
        w_coll_raw[COL_PMISSILE_BORDER]  = playerMissileDR  & borderDR;
        w_coll_raw[COL_MMISSILE_BORDER]  = monsterMissileDR & borderDR;
    end

    assign collision = reset ? '0 : w_coll_raw;

    // ------------------------------------------------------------------
    // Frame accumulator. w_frame_now already includes the current pixel so
    // a collision on the startOfFrame cycle lands in the ending frame.
    // ------------------------------------------------------------------
    frame_collision_t w_frame_now;
    frame_collision_t r_acc;
    frame_collision_t r_frame;
    logic             w_hit;

`ifdef COLLISION_BODY_CONTACT_EN
    logic w_body;
    assign w_body      = ~reset & playerDR & monsterDR;
    assign w_frame_now = r_acc | {w_body, collision};
    assign w_hit       = w_frame_now[COL_MMISSILE_PLAYER] | w_frame_now[COL_BODY_CONTACT];
`else
    assign w_frame_now = r_acc | collision;
    assign w_hit       = w_frame_now[COL_MMISSILE_PLAYER];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_frame <= '0;
        end else if (startOfFrame) begin
            r_frame <= w_frame_now;
            r_acc   <= '0;
        end else begin
            r_acc   <= w_frame_now;
        end
    end

    assign frame_collision = r_frame;

    // ------------------------------------------------------------------
    // Player damage FSM
    // ------------------------------------------------------------------
    player_state_t r_state;
    player_state_t w_state_nxt;
    logic [3:0]    r_lives;
    logic [3:0]    w_lives_nxt;
    logic          r_pulse;
    logic          w_pulse_nxt;
    logic          w_load;
    logic          w_cool_done;

    hit_cooldown #(
        .INVULN_FRAMES (INVULN_FRAMES)
    ) u_cooldown (
        .clk          (clk),
        .reset        (reset),
        .load         (w_load),
        .startOfFrame (startOfFrame),
        .done         (w_cool_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= VULNERABLE;
            r_lives <= c_init_lives;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_pulse_nxt = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            VULNERABLE: begin
                if (startOfFrame && w_hit) begin
                    w_lives_nxt = r_lives - c_one_life;
                    w_pulse_nxt = 1'b1;
                    if (r_lives > c_one_life) begin
                        // A zero-length window keeps the player vulnerable
                        if (INVULN_FRAMES > 0) begin
                            w_state_nxt = INVULN;
                            w_load      = 1'b1;
                        end
                    end else begin
                        w_state_nxt = DEAD;
                    end
                end
            end
            INVULN: begin
                // Hits are ignored here, including on the expiring boundary
                if (w_cool_done) begin
                    w_state_nxt = VULNERABLE;
                end
            end
            DEAD: begin
                w_lives_nxt = '0;
            end
            default: begin
                w_state_nxt = VULNERABLE;
            end
        endcase
    end

    assign player_hit_pulse = r_pulse;
    assign invulnerable     = (r_state == INVULN);
    assign lives            = r_lives;
    assign game_over        = (r_state == DEAD);

endmodule
`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_detector
//  Description : Self-checking bench. Two detector instances share one
//                stimulus stream: dut_a with a 4-frame invulnerability window
//                and dut_b with none. A frame-level model predicts every
//                output and is compared on each falling edge; directed
//                sequences add literal expectations.
//                Honors COLLISION_BODY_CONTACT_EN for the frame summary width.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_detector;

`ifdef COLLISION_BODY_CONTACT_EN
    localparam int FW = 6;
`else
    localparam int FW = 5;
`endif
    localparam int NA   = 4;
    localparam int NB   = 0;
    localparam int INIT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;
    logic startOfFrame = 1'b0;
    logic playerDR = 1'b0, playerMissileDR = 1'b0, monsterDR = 1'b0;
    logic monsterMissileDR = 1'b0, borderDR = 1'b0;

    logic [4:0]    col_a, col_b;
    logic [FW-1:0] fc_a, fc_b;
    logic          pulse_a, pulse_b, inv_a, inv_b, go_a, go_b;
    logic [3:0]    lives_a, lives_b;

    collision_detector #(.INVULN_FRAMES(NA), .INITIAL_LIVES(INIT)) dut_a (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .playerDR(playerDR), .playerMissileDR(playerMissileDR),
        .monsterDR(monsterDR), .monsterMissileDR(monsterMissileDR),
        .borderDR(borderDR), .collision(col_a), .frame_collision(fc_a),
        .player_hit_pulse(pulse_a), .invulnerable(inv_a),
        .lives(lives_a), .game_over(go_a)
    );

    collision_detector #(.INVULN_FRAMES(NB), .INITIAL_LIVES(INIT)) dut_b (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .playerDR(playerDR), .playerMissileDR(playerMissileDR),
        .monsterDR(monsterDR), .monsterMissileDR(monsterMissileDR),
        .borderDR(borderDR), .collision(col_b), .frame_collision(fc_b),
        .player_hit_pulse(pulse_b), .invulnerable(inv_b),
        .lives(lives_b), .game_over(go_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame-level bookkeeping straight from the rules
    // ------------------------------------------------------------------
    logic [FW-1:0] cin;
    logic [FW-1:0] acc_m, frame_m;
    logic          hit_m;
    int            lives_m [2];
    int            left_m  [2];
    logic          dead_m  [2];
    logic          pulse_m [2];

`ifdef COLLISION_BODY_CONTACT_EN
    assign cin   = {playerDR & monsterDR,
                    monsterMissileDR & borderDR, playerMissileDR & borderDR,
                    monsterMissileDR & playerDR, monsterDR & borderDR,
                    playerMissileDR & monsterDR};
    assign hit_m = acc_m[2] | cin[2] | acc_m[5] | cin[5];
`else
    assign cin   = {monsterMissileDR & borderDR, playerMissileDR & borderDR,
                    monsterMissileDR & playerDR, monsterDR & borderDR,
                    playerMissileDR & monsterDR};
    assign hit_m = acc_m[2] | cin[2];
`endif

    function automatic int window(input int i);
        return (i == 0) ? NA : NB;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_m   <= '0;
            frame_m <= '0;
            for (int i = 0; i < 2; i++) begin
                lives_m[i] <= INIT;
                left_m[i]  <= 0;
                dead_m[i]  <= 1'b0;
                pulse_m[i] <= 1'b0;
            end
        end else begin
            if (startOfFrame) begin
                frame_m <= acc_m | cin;
                acc_m   <= '0;
            end else begin
                acc_m   <= acc_m | cin;
            end
            for (int i = 0; i < 2; i++) begin
                pulse_m[i] <= 1'b0;
                if (startOfFrame && !dead_m[i]) begin
                    if (left_m[i] > 0) begin
                        left_m[i] <= left_m[i] - 1;
                    end else if (hit_m) begin
                        lives_m[i] <= lives_m[i] - 1;
                        pulse_m[i] <= 1'b1;
                        if (lives_m[i] == 1) dead_m[i] <= 1'b1;
                        else                 left_m[i] <= window(i);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Continuous compare, away from the rising edge
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("collision_a", int'(col_a), reset ? 0 : int'(cin[4:0]));
            chk("collision_b", int'(col_b), reset ? 0 : int'(cin[4:0]));
            chk("frame_a", int'(fc_a), int'(frame_m));
            chk("frame_b", int'(fc_b), int'(frame_m));
            chk("pulse_a", int'(pulse_a), int'(pulse_m[0]));
            chk("pulse_b", int'(pulse_b), int'(pulse_m[1]));
            chk("invuln_a", int'(inv_a), int'(left_m[0] > 0));
            chk("invuln_b", int'(inv_b), int'(left_m[1] > 0));
            chk("lives_a", int'(lives_a), lives_m[0]);
            chk("lives_b", int'(lives_b), lives_m[1]);
            chk("game_over_a", int'(go_a), int'(dead_m[0]));
            chk("game_over_b", int'(go_b), int'(dead_m[1]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step(input logic r, input logic s, input logic pl, input logic pm,
                        input logic m, input logic mm, input logic b);
        @(negedge clk);
        reset            = r;
        startOfFrame     = s;
        playerDR         = pl;
        playerMissileDR  = pm;
        monsterDR        = m;
        monsterMissileDR = mm;
        borderDR         = b;
    endtask

    // one frame of three cycles carrying a player hit, result visible after
    task automatic hit_frame();
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #3;
    endtask

    initial begin
        int gap;
        #1 reset = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_lives", int'(lives_a), 3);
        chk("reset_frame", int'(fc_a), 0);
        chk("reset_invuln", int'(inv_a), 0);
        chk("reset_game_over", int'(go_a), 0);
        chk("reset_pulse", int'(pulse_a), 0);

        // player missile on monster for three cycles
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 1, 0, 0);
            #3;
            chk("pm_monster_vec", int'(col_a), 1);
        end
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("pm_monster_frame", int'(fc_a), 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("quiet_frame", int'(fc_a), 0);

        // collision only on the startOfFrame cycle belongs to the ending frame
        step(0, 1, 0, 1, 0, 0, 1);
        #3;
        chk("sof_vec", int'(col_a), 8);
        step(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("sof_frame", int'(fc_a), 8);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("sof_acc_clear", int'(fc_a), 0);

        // first hit: both lose a life, only dut_a becomes invulnerable
        hit_frame();
        chk("hit1_pulse_a", int'(pulse_a), 1);
        chk("hit1_lives_a", int'(lives_a), 2);
        chk("hit1_invuln_a", int'(inv_a), 1);
        chk("hit1_pulse_b", int'(pulse_b), 1);
        chk("hit1_lives_b", int'(lives_b), 2);
        chk("hit1_invuln_b", int'(inv_b), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("hit1_pulse_once", int'(pulse_a), 0);

        // four more hit frames: dut_a protected, dut_b runs out of lives
        for (int k = 0; k < 4; k++) begin
            hit_frame();
            chk("inv_pulse_a", int'(pulse_a), 0);
            chk("inv_flag_a", int'(inv_a), int'(k < 3));
            chk("inv_lives_a", int'(lives_a), 2);
            chk("chain_pulse_b", int'(pulse_b), int'(k < 2));
            chk("chain_lives_b", int'(lives_b), (k == 0) ? 1 : 0);
            chk("chain_over_b", int'(go_b), int'(k >= 1));
        end

        // dut_a vulnerable again: down to one life, invulnerable
        hit_frame();
        chk("hit2_lives_a", int'(lives_a), 1);
        chk("hit2_pulse_a", int'(pulse_a), 1);
        chk("hit2_invuln_a", int'(inv_a), 1);

        // asynchronous reset between clock edges
        @(posedge clk);
        #3;
        reset           = 1'b1;
        monsterDR       = 1'b1;
        playerMissileDR = 1'b1;
        #1;
        chk("areset_lives_a", int'(lives_a), 3);
        chk("areset_invuln_a", int'(inv_a), 0);
        chk("areset_lives_b", int'(lives_b), 3);
        chk("areset_over_b", int'(go_b), 0);
        chk("areset_vec", int'(col_a), 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // randomized traffic, including back-to-back frame starts
        gap = 0;
        for (int n = 0; n < 3000; n++) begin
            logic s;
            logic r;
            s = (gap == 0);
            if (s) gap = $urandom_range(0, 5);
            else   gap--;
            r = ($urandom_range(0, 149) == 0);
            step(r, s,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0);
        end

        step(0, 0, 0, 0, 0, 0, 0);
        #4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
